audio_data_in_pio: RTL and testbench

//  Avalon-MM slave input port: the receive-side counterpart of the 16-bit output PIO.
//  It samples an external 16-bit bus (audio codec / FPGA fabric -> HPS) through a synchronizer.
//  It latches per-bit edge events and raises a maskable interrupt to the processor.
//  It sits in the QSYS system beside the output PIO on the same lightweight bridge.

---
 rtl/audio_data_in_pio.sv | 104 ++++++++++
 tb/tb_audio_data_in_pio.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_data_in_pio.sv
// audio_data_in_pio: Avalon-MM input PIO with synchronizer,
// per-bit edge capture and a maskable level interrupt.
module audio_data_in_pio #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;

    logic [WIDTH-1:0] w_data_sync;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_edgecap_next;
    logic [WIDTH-1:0] w_irqmask_next;
    logic [31:0]      w_rd;
    logic             w_wr;
    logic             w_unused;

    assign w_data_sync = r_sync[SYNC_STAGES-1];
    assign w_wr        = chipselect & ~write_n;
    assign w_unused    = &{1'b0, writedata};

    // Synchronize the asynchronous bus and keep a one-cycle-old copy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_data_sync;
        end
    end

    // Per-bit edge detector; the parameter picks the sensitive edge.
    always_comb begin
        w_edge = '0;
        case (EDGE_TYPE)
            0:       w_edge = w_data_sync & ~r_prev;
            1:       w_edge = ~w_data_sync & r_prev;
            default: w_edge = w_data_sync ^ r_prev;
        endcase
    end

    // Next-state for capture and mask; a new edge beats a clear.
    always_comb begin
        w_clr          = '0;
        w_irqmask_next = r_irqmask;
        if (w_wr && address == 2'd3) begin
            w_clr = writedata[WIDTH-1:0];
        end
        if (w_wr && address == 2'd1) begin
            w_irqmask_next = writedata[WIDTH-1:0];
        end
        w_edgecap_next = (r_edgecap & ~w_clr) | w_edge;
    end

    // Read mux, zero-extended to the 32-bit bus.
    always_comb begin
        w_rd = '0;
        case (address)
            2'd0:    w_rd[WIDTH-1:0] = w_data_sync;
            2'd1:    w_rd[WIDTH-1:0] = r_irqmask;
            2'd3:    w_rd[WIDTH-1:0] = r_edgecap;
            default: w_rd = '0;
        endcase
    end

    // Register state, read data and the interrupt line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irqmask <= '0;
            r_edgecap <= '0;
            readdata  <= '0;
            irq       <= 1'b0;
        end else begin
            r_irqmask <= w_irqmask_next;
            r_edgecap <= w_edgecap_next;
            if (chipselect) begin
                readdata <= w_rd;
            end
            irq <= |(w_edgecap_next & w_irqmask_next);
        end
    end

endmodule

// File: tb/tb_audio_data_in_pio.sv
// tb_audio_data_in_pio: directed plus random checks of three
// edge-type variants against a history-based reference model.
module tb_audio_data_in_pio;

    localparam int W = 16;
    localparam int S = 2;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          cs      = 1'b0;
    logic          write_n = 1'b1;
    logic [1:0]    addr    = '0;
    logic [31:0]   wd      = '0;
    logic [W-1:0]  pin     = '0;
    logic [31:0]   rdat [3];
    logic          irqv [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        audio_data_in_pio #(
            .WIDTH      (W),
            .SYNC_STAGES(S),
            .EDGE_TYPE  (g)
        ) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .address   (addr),
            .chipselect(cs),
            .write_n   (write_n),
            .writedata (wd),
            .in_port   (pin),
            .readdata  (rdat[g]),
            .irq       (irqv[g])
        );
    end

    logic [W-1:0] hist [$];
    logic [W-1:0] mmask;
    logic [W-1:0] mcap [3];
    logic [31:0]  mrd  [3];
    logic         mirq [3];

    function automatic logic [W-1:0] edges(input logic [W-1:0] cur,
                                           input logic [W-1:0] old,
                                           input int kind);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            bit up, dn;
            up = cur[i] && !old[i];
            dn = !cur[i] && old[i];
            r[i] = (kind == 0) ? up : (kind == 1) ? dn : (up || dn);
        end
        return r;
    endfunction

    // Reference: data_sync is the input seen S edges ago,
    // prev is the one seen S+1 edges ago.
    always @(posedge clk or negedge reset_n) begin : model
        logic [W-1:0] ds, pv, clr, capn, mskn;
        logic wr;
        if (!reset_n) begin
            hist.delete();
            for (int i = 0; i <= S; i++) hist.push_back('0);
            mmask = '0;
            for (int t = 0; t < 3; t++) begin
                mcap[t] = '0;
                mrd[t]  = '0;
                mirq[t] = 1'b0;
            end
        end else begin
            ds   = hist[S-1];
            pv   = hist[S];
            wr   = cs && !write_n;
            clr  = (wr && addr == 2'd3) ? wd[W-1:0] : '0;
            mskn = (wr && addr == 2'd1) ? wd[W-1:0] : mmask;
            for (int t = 0; t < 3; t++) begin
                capn = (mcap[t] & ~clr) | edges(ds, pv, t);
                if (cs) begin
                    case (addr)
                        2'd0: mrd[t] = {16'h0, ds};
                        2'd1: mrd[t] = {16'h0, mmask};
                        2'd2: mrd[t] = 32'h0;
                        default: mrd[t] = {16'h0, mcap[t]};
                    endcase
                end
                mirq[t] = |(capn & mskn);
                mcap[t] = capn;
            end
            mmask = mskn;
            hist.push_front(pin);
            void'(hist.pop_back());
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmp_all();
        for (int t = 0; t < 3; t++) begin
            check($sformatf("model_rd%0d", t), rdat[t], mrd[t]);
            check($sformatf("model_irq%0d", t), 32'(irqv[t]), 32'(mirq[t]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) begin
            tick();
            cmp_all();
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cs = 1'b1; write_n = 1'b0; addr = a; wd = d;
        tick();
        cs = 1'b0; write_n = 1'b1;
        cmp_all();
    endtask

    task automatic rd(input logic [1:0] a);
        cs = 1'b1; write_n = 1'b1; addr = a;
        tick();
        cs = 1'b0;
        cmp_all();
    endtask

    initial begin
        // T1 reset with all inputs high
        reset_n = 1'b0;
        pin = 16'hFFFF;
        repeat (3) tick();
        for (int t = 0; t < 3; t++) begin
            check("rst_rd", rdat[t], 32'h0);
            check("rst_irq", 32'(irqv[t]), 32'h0);
        end
        reset_n = 1'b1;
        wait_n(3);
        rd(2'd0);
        check("t1_data", rdat[0], 32'h0000FFFF);

        // T2 rising capture
        pin = 16'h0000;
        wait_n(4);
        wr(2'd3, 32'hFFFFFFFF);
        rd(2'd3);
        for (int t = 0; t < 3; t++) check("t2_clr", rdat[t], 32'h0);
        pin = 16'h0005;
        wait_n(2);
        rd(2'd3);
        check("t2_early", rdat[0], 32'h0);
        rd(2'd3);
        check("t2_set", rdat[0], 32'h00000005);
        pin = 16'h0000;
        wait_n(4);
        rd(2'd3);
        check("t2_hold", rdat[0], 32'h00000005);

        // T3 interrupt mask and clear
        wr(2'd1, 32'h00000004);
        check("t3_irq_on", 32'(irqv[0]), 32'h1);
        wr(2'd3, 32'h00000004);
        check("t3_irq_off", 32'(irqv[0]), 32'h0);
        rd(2'd3);
        check("t3_cap", rdat[0], 32'h00000001);

        // T4 set beats clear on the same cycle
        wr(2'd3, 32'h0000FFFF);
        pin = 16'h0001;
        wait_n(2);
        wr(2'd3, 32'h00000001);
        rd(2'd3);
        check("t4_collide", rdat[0], 32'h00000001);

        // T5 falling / any edge variants
        pin = 16'h0000;
        wait_n(4);
        wr(2'd3, 32'h0000FFFF);
        pin = 16'h8000;
        wait_n(4);
        rd(2'd3);
        check("t5_fall_on_rise", rdat[1], 32'h0);
        check("t5_any_on_rise", rdat[2], 32'h00008000);
        wr(2'd3, 32'h0000FFFF);
        pin = 16'h0000;
        wait_n(4);
        rd(2'd3);
        check("t5_fall_on_fall", rdat[1], 32'h00008000);
        check("t5_any_on_fall", rdat[2], 32'h00008000);
        check("t5_rise_on_fall", rdat[0], 32'h0);

        // T6 writes to DATA and reserved are ignored
        pin = 16'h1234;
        wait_n(4);
        wr(2'd0, 32'hDEADBEEF);
        wr(2'd2, 32'hDEADBEEF);
        rd(2'd0);
        check("t6_data", rdat[0], 32'h00001234);
        rd(2'd2);
        check("t6_resv", rdat[0], 32'h0);
        rd(2'd1);
        check("t6_mask", rdat[0], 32'h00000004);
        rd(2'd3);
        check("t6_cap", rdat[0], 32'h00001234);

        // Reset in mid-cycle drops a pending interrupt at once
        wr(2'd1, 32'h0000FFFF);
        check("mid_irq_pre", 32'(irqv[0]), 32'h1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        for (int t = 0; t < 3; t++) begin
            check("mid_rst_rd", rdat[t], 32'h0);
            check("mid_rst_irq", 32'(irqv[t]), 32'h0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_n(2);

        // Random traffic against the model
        repeat (300) begin
            pin     = W'($urandom);
            cs      = 1'($urandom_range(0, 1));
            write_n = ($urandom_range(0, 3) != 0);
            addr    = 2'($urandom);
            wd      = $urandom;
            tick();
            cmp_all();
        end
        cs = 1'b0;
        write_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
